cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Shared word array serving fetch, two register reads, one register write and
// the MEM-stage data port, plus a backpressured full-array dump stream.
module cpu_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       ins_addr,
    output logic [DATA_W-1:0] ins_data,
    input  logic [31:0]       load_pc_reg_addr1,
    input  logic [31:0]       load_pc_reg_addr2,
    output logic [DATA_W-1:0] load_pc_reg_value1,
    output logic [DATA_W-1:0] load_pc_reg_value2,
    input  logic              write_ctrl_input,
    input  logic [31:0]       write_pc_reg_addr,
    input  logic [DATA_W-1:0] write_pc_reg_value,
    input  logic [1:0]        mem_ctrl_input,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] read_data,
    output logic              err_illegal,
    output logic              err_range,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> ADDR_W) == 32'd0;
    endfunction

    function automatic logic [ADDR_W-1:0] idx(input logic [31:0] a);
        return a[ADDR_W-1:0];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic rd_en, wr_en, ill_en, reg_we_ok, dat_we_ok, rng_hit;

    always_comb begin
        rd_en     = (mem_ctrl_input == 2'b10);
        wr_en     = (mem_ctrl_input == 2'b01);
        ill_en    = (mem_ctrl_input == 2'b11);
        reg_we_ok = write_ctrl_input && in_rng(write_pc_reg_addr);
        dat_we_ok = wr_en && in_rng(address);
        rng_hit   = !in_rng(ins_addr)
                  || !in_rng(load_pc_reg_addr1)
                  || !in_rng(load_pc_reg_addr2)
                  || ((rd_en || wr_en) && !in_rng(address))
                  || (write_ctrl_input && !in_rng(write_pc_reg_addr));
    end

    // Data-port write is issued last so it wins on a same-index collision.
    always_ff @(posedge clk) begin
        if (reg_we_ok) mem[idx(write_pc_reg_addr)] <= write_pc_reg_value;
        if (dat_we_ok) mem[idx(address)] <= w_data;
    end

    logic [DATA_W-1:0] ins_q, v1_q, v2_q, rd_q;
    logic              ill_q, rng_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ins_q <= '0;
            v1_q  <= '0;
            v2_q  <= '0;
            rd_q  <= '0;
            ill_q <= 1'b0;
            rng_q <= 1'b0;
        end else begin
            ins_q <= in_rng(ins_addr) ? mem[idx(ins_addr)] : '0;
            v1_q  <= in_rng(load_pc_reg_addr1) ? mem[idx(load_pc_reg_addr1)] : '0;
            v2_q  <= in_rng(load_pc_reg_addr2) ? mem[idx(load_pc_reg_addr2)] : '0;
            if (rd_en) rd_q <= in_rng(address) ? mem[idx(address)] : '0;
            ill_q <= ill_q | ill_en;
            rng_q <= rng_q | rng_hit;
        end
    end

    assign ins_data           = ins_q;
    assign load_pc_reg_value1 = v1_q;
    assign load_pc_reg_value2 = v2_q;
    assign read_data          = rd_q;
    assign err_illegal        = ill_q;
    assign err_range          = rng_q;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] ddata_q, ddata_d;
    logic              dvalid_q, dvalid_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            daddr_q  <= '0;
            ddata_q  <= '0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            daddr_q  <= daddr_d;
            ddata_q  <= ddata_d;
            dvalid_q <= dvalid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        daddr_d  = daddr_q;
        ddata_d  = ddata_q;
        dvalid_d = dvalid_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = DUMP;
                    ptr_d   = '0;
                end
            end
            DUMP: begin
                // Accepting the final beat ends the walk; no wrap-around beat.
                if (dvalid_q && dump_ready && daddr_q == LAST) begin
                    state_d  = DONE;
                    dvalid_d = 1'b0;
                    done_d   = 1'b1;
                end else if (!dvalid_q || dump_ready) begin
                    ddata_d  = mem[ptr_q];
                    daddr_d  = ptr_q;
                    dvalid_d = 1'b1;
                    ptr_d    = ptr_q + ADDR_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dump_valid = dvalid_q;
    assign dump_addr  = daddr_q;
    assign dump_data  = ddata_q;
    assign dump_done  = done_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed vectors, a behavioural array model
// and a per-cycle compare process including a dump stream protocol checker.
module tb_cpu_mem_responder;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   ins_addr, a1, a2, waddr, address;
    logic [DW-1:0] ins_data, v1, v2, wval, w_data, read_data, dump_data;
    logic          we, err_illegal, err_range;
    logic [1:0]    ctrl;
    logic          dump_start, dump_valid, dump_ready, dump_done;
    logic [AW-1:0] dump_addr;

    always #5 clk = ~clk;

    cpu_mem_responder #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ins_addr(ins_addr), .ins_data(ins_data),
        .load_pc_reg_addr1(a1), .load_pc_reg_addr2(a2),
        .load_pc_reg_value1(v1), .load_pc_reg_value2(v2),
        .write_ctrl_input(we), .write_pc_reg_addr(waddr),
        .write_pc_reg_value(wval),
        .mem_ctrl_input(ctrl), .address(address), .w_data(w_data),
        .read_data(read_data),
        .err_illegal(err_illegal), .err_range(err_range),
        .dump_start(dump_start), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Behavioural model: array plus expected registered outputs.
    logic [31:0] m_mem [N];
    logic [31:0] e_ins, e_v1, e_v2, e_rd;
    logic        e_ill, e_rng;

    function automatic bit oor(input logic [31:0] a);
        return a >= N;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return oor(a) ? 32'd0 : m_mem[a[3:0]];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_ins = 0; e_v1 = 0; e_v2 = 0; e_rd = 0;
            e_ill = 0; e_rng = 0;
        end else begin
            e_ins = rd(ins_addr);
            e_v1  = rd(a1);
            e_v2  = rd(a2);
            if (oor(ins_addr) || oor(a1) || oor(a2)) e_rng = 1;
            if (ctrl == 2'b10) e_rd = rd(address);
            if (ctrl == 2'b11) e_ill = 1;
            if ((ctrl == 2'b10 || ctrl == 2'b01) && oor(address)) e_rng = 1;
            if (we && oor(waddr)) e_rng = 1;
            if (we && !oor(waddr)) m_mem[waddr[3:0]] = wval;
            if (ctrl == 2'b01 && !oor(address)) m_mem[address[3:0]] = w_data;
        end
    end

    int          exp_idx = 0;
    int          beats = 0;
    bit          exp_done = 0;
    bit          p_valid = 0, p_ready = 0;
    logic [3:0]  p_addr;
    logic [31:0] p_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_idx = 0; exp_done = 0; p_valid = 0; p_ready = 0;
        end else if (cmp_on) begin
            chk("ins_data", ins_data, e_ins);
            chk("reg_value1", v1, e_v1);
            chk("reg_value2", v2, e_v2);
            chk("read_data", read_data, e_rd);
            chk("err_illegal", {31'd0, err_illegal}, {31'd0, e_ill});
            chk("err_range", {31'd0, err_range}, {31'd0, e_rng});
            chk("dump_done", {31'd0, dump_done}, {31'd0, exp_done});
            if (exp_done) chk("valid_after_last", {31'd0, dump_valid}, 0);
            if (p_valid && !p_ready) begin
                chk("hold_valid", {31'd0, dump_valid}, 1);
                chk("hold_addr", {28'd0, dump_addr}, {28'd0, p_addr});
                chk("hold_data", dump_data, p_data);
            end
            if (dump_valid) begin
                chk("beat_addr", {28'd0, dump_addr}, 32'(exp_idx));
                chk("beat_data", dump_data, m_mem[dump_addr]);
            end
            exp_done = dump_valid && dump_ready && (dump_addr == 4'(N - 1));
            if (dump_valid && dump_ready) begin
                beats++;
                exp_idx = (exp_idx + 1) % N;
            end
            p_valid = dump_valid;
            p_ready = dump_ready;
            p_addr  = dump_addr;
            p_data  = dump_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill;
        for (int i = 0; i < N; i++) begin
            ctrl = 2'b01; address = i; w_data = i ^ 32'h5A;
            tick;
        end
        ctrl = 2'b00;
    endtask

    int n, b0;

    initial begin
        reset_n = 0; ins_addr = 0; a1 = 0; a2 = 0; we = 0; waddr = 0;
        wval = 0; ctrl = 0; address = 0; w_data = 0;
        dump_start = 0; dump_ready = 0;
        repeat (2) tick;
        chk("rst_ins", ins_data, 0);
        chk("rst_v1", v1, 0);
        chk("rst_v2", v2, 0);
        chk("rst_rd", read_data, 0);
        chk("rst_flags", {28'd0, dump_valid, dump_done, err_illegal, err_range}, 0);
        chk("rst_daddr", {28'd0, dump_addr}, 0);
        chk("rst_ddata", dump_data, 0);
        reset_n = 1;
        tick;
        fill;
        tick;
        cmp_on = 1;

        ctrl = 2'b01; address = 5; w_data = 32'hDEADBEEF;
        tick;
        ctrl = 2'b10; ins_addr = 5;
        tick;
        chk("wr_rd_5", read_data, 32'hDEADBEEF);
        chk("fetch_5", ins_data, 32'hDEADBEEF);

        ctrl = 2'b01; address = 7; w_data = 32'h22;
        we = 1; waddr = 7; wval = 32'h11;
        tick;
        ctrl = 2'b00; we = 0; a1 = 7;
        tick;
        chk("same_idx_win", v1, 32'h22);
        ctrl = 2'b01; address = 8; w_data = 32'h22;
        we = 1; waddr = 7; wval = 32'h11;
        tick;
        ctrl = 2'b00; we = 0; a1 = 7; a2 = 8;
        tick;
        chk("dual_wr_7", v1, 32'h11);
        chk("dual_wr_8", v2, 32'h22);

        ctrl = 2'b01; address = 3; w_data = 32'hA;
        tick;
        w_data = 32'hB; ins_addr = 3; a1 = 3;
        tick;
        chk("rbw_fetch", ins_data, 32'hA);
        chk("rbw_reg", v1, 32'hA);
        ctrl = 2'b10; we = 1; waddr = 3; wval = 32'hC;
        tick;
        chk("rbw_data", read_data, 32'hB);
        chk("new_fetch", ins_data, 32'hB);
        ctrl = 2'b00; we = 0;
        tick;
        chk("after_wr", ins_data, 32'hC);
        chk("no_ill_yet", {31'd0, err_illegal}, 0);
        chk("no_rng_yet", {31'd0, err_range}, 0);

        ctrl = 2'b11; address = 4; w_data = 32'h77;
        tick;
        chk("ill_set", {31'd0, err_illegal}, 1);
        chk("ill_hold_rd", read_data, 32'hB);
        ctrl = 2'b00; ins_addr = 4;
        tick;
        chk("ill_sticky", {31'd0, err_illegal}, 1);
        chk("ill_no_wr", ins_data, 32'h5E);

        ins_addr = 32'h10;
        tick;
        chk("oor_fetch", ins_data, 0);
        chk("rng_set", {31'd0, err_range}, 1);
        ins_addr = 0; ctrl = 2'b10; address = 32'h400;
        tick;
        chk("oor_read", read_data, 0);
        ctrl = 2'b00; we = 1; waddr = 32'h13; wval = 32'h99;
        tick;
        we = 0; ins_addr = 3;
        tick;
        chk("oor_regwr", ins_data, 32'hC);
        ctrl = 2'b01; address = 32'h14; w_data = 32'h55;
        tick;
        ctrl = 2'b00; ins_addr = 4;
        tick;
        chk("oor_datwr", ins_data, 32'h5E);

        fill;
        tick;
        b0 = beats;
        dump_start = 1;
        tick;
        dump_start = 0;
        chk("beat_lat_1", {31'd0, dump_valid}, 0);
        tick;
        chk("beat_lat_2", {31'd0, dump_valid}, 1);
        chk("first_addr", {28'd0, dump_addr}, 0);
        chk("first_data", dump_data, 32'h5A);
        n = 0;
        while (!dump_done && n < 200) begin
            dump_ready = ~dump_ready;
            tick;
            n++;
        end
        chk("dump1_timeout", {31'd0, dump_done}, 1);
        chk("dump1_beats", 32'(beats - b0), 16);
        dump_ready = 0;
        tick;
        chk("done_one_cycle", {31'd0, dump_done}, 0);

        dump_ready = 1; dump_start = 1;
        tick;
        dump_start = 0;
        n = 0;
        while (!(dump_valid && dump_addr == 4'd6) && n < 50) begin
            tick;
            n++;
        end
        chk("reach_beat6", {31'd0, dump_valid}, 1);
        #2 reset_n = 0;
        #1 chk("async_abort", {31'd0, dump_valid}, 0);
        tick;
        tick;
        reset_n = 1;
        tick;
        chk("idle_after_rst", {31'd0, dump_valid}, 0);

        dump_start = 1;
        tick;
        n = 1;
        dump_start = 0;
        tick;
        n++;
        chk("restart_addr", {28'd0, dump_addr}, 0);
        while (!dump_done && n < 100) begin
            dump_start = (n == 5);
            tick;
            n++;
        end
        dump_start = 0;
        chk("dump_latency", 32'(n), 18);
        tick;
        chk("back_idle", {30'd0, dump_valid, dump_done}, 0);

        cmp_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
